// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, handshaked memory read with wait states, instruction register, branch redirect.
// Optional FETCH_REL_BRANCH_EN: branch_target is a signed offset from pc+1 instead of an absolute address.
//
// state | meaning
// FETCH | idle / ready to issue a read at pc (blocked while halt=1)
// WAIT  | mem_req held until mem_ack; a branch here is deferred via redirect_pending
// HOLD  | instruction register holds an unconsumed word until instr_ack
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ack,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               pc_wrap
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t             state;
  logic               redirect_pending;
  logic [ADDR_W-1:0]  pending_addr;
  logic [ADDR_W-1:0]  redir_addr;

`ifdef FETCH_REL_BRANCH_EN
  // pc is stable during WAIT, so resolving the offset at latch time is safe
  assign redir_addr = pc + ADDR_W'(1) + branch_target;
`else
  assign redir_addr = branch_target;
`endif

  assign mem_addr = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= FETCH;
      pc               <= RESET_PC;
      mem_req          <= 1'b0;
      instruction      <= '0;
      instr_valid      <= 1'b0;
      pc_wrap          <= 1'b0;
      redirect_pending <= 1'b0;
      pending_addr     <= '0;
    end else begin
      pc_wrap <= 1'b0;
      case (state)
        FETCH: begin
          if (branch_en) begin
            pc <= redir_addr;
          end else if (!halt) begin
            mem_req <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req          <= 1'b0;
            redirect_pending <= 1'b0;
            state            <= FETCH;
            // a branch arriving with the ack also discards the returning word
            if (branch_en) begin
              pc <= redir_addr;
            end else if (redirect_pending) begin
              pc <= pending_addr;
            end else begin
              instruction <= mem_rdata;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end
          end else if (branch_en) begin
            pending_addr     <= redir_addr;
            redirect_pending <= 1'b1;
          end
        end
        HOLD: begin
          if (branch_en) begin
            pc          <= redir_addr;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end else if (instr_ack) begin
            pc          <= pc + ADDR_W'(1);
            pc_wrap     <= &pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit: per-cycle input/expected-output records plus async-reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ack;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic [7:0]  pc;
  logic        pc_wrap;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .branch_en(branch_en), .branch_target(branch_target), .pc(pc), .pc_wrap(pc_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halt;
    logic        ack;
    logic [15:0] rdata;
    logic        iack;
    logic        br;
    logic [7:0]  tgt;
    logic        e_req;
    logic        e_iv;
    logic [15:0] e_instr;
    logic [7:0]  e_pc;
    logic        e_wrap;
  } vec_t;

  vec_t vecs[$];

  // branch_target field that lands on absolute address 'want' from current pc
  function automatic logic [7:0] tgt_for(input logic [7:0] pc_now, input logic [7:0] want);
`ifdef FETCH_REL_BRANCH_EN
    return want - pc_now - 8'd1;
`else
    return want;
`endif
  endfunction

  function automatic vec_t mk(input logic h, input logic a, input logic [15:0] rd, input logic ia,
                              input logic b, input logic [7:0] t, input logic er, input logic ev,
                              input logic [15:0] ei, input logic [7:0] ep, input logic ew);
    vec_t v;
    v.halt = h; v.ack = a; v.rdata = rd; v.iack = ia; v.br = b; v.tgt = t;
    v.e_req = er; v.e_iv = ev; v.e_instr = ei; v.e_pc = ep; v.e_wrap = ew;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_state(input int idx);
    chk("rst_mem_req", idx, 32'(mem_req), 32'd0);
    chk("rst_instr_valid", idx, 32'(instr_valid), 32'd0);
    chk("rst_instruction", idx, 32'(instruction), 32'd0);
    chk("rst_pc", idx, 32'(pc), 32'd0);
    chk("rst_mem_addr", idx, 32'(mem_addr), 32'd0);
    chk("rst_pc_wrap", idx, 32'(pc_wrap), 32'd0);
  endtask

  localparam logic [7:0] P_REL = 8'h0D;
  localparam logic [7:0] P_ABS = 8'hFC;
`ifdef FETCH_REL_BRANCH_EN
  localparam logic [7:0] P6 = P_REL;
`else
  localparam logic [7:0] P6 = P_ABS;
`endif

  initial begin
    //             halt ack rdata    iack br tgt                   req iv instr    pc     wrap
    // reset release, zero-wait fetch, consume
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h0000, 8'h00, 0));
    vecs.push_back(mk(0, 1, 16'hA5A5, 0, 0, 8'h00,               0, 1, 16'hA5A5, 8'h00, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h00,               0, 0, 16'hA5A5, 8'h01, 0));
    // three wait states: mem_req high for four samples at a stable address
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'hA5A5, 8'h01, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'hA5A5, 8'h01, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'hA5A5, 8'h01, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'hA5A5, 8'h01, 0));
    vecs.push_back(mk(0, 1, 16'h1234, 0, 0, 8'h00,               0, 1, 16'h1234, 8'h01, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h00,               0, 0, 16'h1234, 8'h02, 0));
    // branch during WAIT: word discarded, refetch at 0x40
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h1234, 8'h02, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, tgt_for(8'h02, 8'h40), 1, 0, 16'h1234, 8'h02, 0));
    vecs.push_back(mk(0, 1, 16'hBEEF, 0, 0, 8'h00,               0, 0, 16'h1234, 8'h40, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h1234, 8'h40, 0));
    vecs.push_back(mk(0, 1, 16'h4040, 0, 0, 8'h00,               0, 1, 16'h4040, 8'h40, 0));
    // branch in HOLD beats instr_ack; then wrap FF -> 00
    vecs.push_back(mk(0, 0, 16'h0000, 1, 1, tgt_for(8'h40, 8'hFF), 0, 0, 16'h4040, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h4040, 8'hFF, 0));
    vecs.push_back(mk(0, 1, 16'h00FF, 0, 0, 8'h00,               0, 1, 16'h00FF, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 8'h00,               0, 0, 16'h00FF, 8'h00, 1));
    // halt blocks only FETCH->WAIT
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,               0, 0, 16'h00FF, 8'h00, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h00FF, 8'h00, 0));
    vecs.push_back(mk(1, 1, 16'h0101, 0, 0, 8'h00,               0, 1, 16'h0101, 8'h00, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,               0, 0, 16'h0101, 8'h01, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 8'h00,               0, 0, 16'h0101, 8'h01, 0));
    vecs.push_back(mk(1, 1, 16'h7777, 0, 0, 8'h00,               0, 0, 16'h0101, 8'h01, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h0101, 8'h01, 0));
    vecs.push_back(mk(0, 1, 16'h2222, 0, 0, 8'h00,               0, 1, 16'h2222, 8'h01, 0));
    // get to pc=0x10 in HOLD, then raw target 0xFC
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, tgt_for(8'h01, 8'h10), 0, 0, 16'h2222, 8'h10, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h2222, 8'h10, 0));
    vecs.push_back(mk(0, 1, 16'h3333, 0, 0, 8'h00,               0, 1, 16'h3333, 8'h10, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 8'hFC,               0, 0, 16'h3333, P6,    0));
    // instr_ack in FETCH ignored; second branch in WAIT overwrites the first
    vecs.push_back(mk(1, 0, 16'h0000, 1, 0, 8'h00,               0, 0, 16'h3333, P6,    0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h3333, P6,    0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, tgt_for(P6, 8'h20),  1, 0, 16'h3333, P6,    0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, tgt_for(P6, 8'h30),  1, 0, 16'h3333, P6,    0));
    vecs.push_back(mk(0, 1, 16'h5555, 0, 0, 8'h00,               0, 0, 16'h3333, 8'h30, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 8'h00,               1, 0, 16'h3333, 8'h30, 0));

    reset = 1'b0; halt = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    instr_ack = 1'b0; branch_en = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_state(-1);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      halt = vecs[i].halt; mem_ack = vecs[i].ack; mem_rdata = vecs[i].rdata;
      instr_ack = vecs[i].iack; branch_en = vecs[i].br; branch_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk("mem_req", i, 32'(mem_req), 32'(vecs[i].e_req));
      chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_iv));
      chk("instruction", i, 32'(instruction), 32'(vecs[i].e_instr));
      chk("pc", i, 32'(pc), 32'(vecs[i].e_pc));
      chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].e_pc));
      chk("pc_wrap", i, 32'(pc_wrap), 32'(vecs[i].e_wrap));
    end

    // async reset mid-WAIT: outputs clear without a clock edge
    @(negedge clk);
    halt = 1'b0; mem_ack = 1'b0; instr_ack = 1'b0; branch_en = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_state(100);
    @(negedge clk);
    reset = 1'b1;

    // latency after release: ack offered before mem_req is ignored, then zero-wait fetch
    mem_ack = 1'b1; mem_rdata = 16'hC3C3;
    @(posedge clk);
    #1;
    chk("lat_req_edge1", 101, 32'(mem_req), 32'd1);
    chk("lat_iv_edge1", 101, 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_iv_edge2", 102, 32'(instr_valid), 32'd1);
    chk("lat_instr_edge2", 102, 32'(instruction), 32'hC3C3);
    chk("lat_req_edge2", 102, 32'(mem_req), 32'd0);
    chk("lat_pc_edge2", 102, 32'(pc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
